// File: rtl/btn_toggle_gen_if.sv
// Button-to-toggle interface: raw button and enable in, debounced level,
// toggle request, busy flag and press counter out.
interface btn_toggle_gen_if #(
    parameter int CNT_W = 8
) ();
    logic             btn;
    logic             en;
    logic             t;
    logic             db;
    logic             busy;
    logic [CNT_W-1:0] press_cnt;

    // Stimulus / system side: drives the button and enable.
    modport master (
        output btn, en,
        input  t, db, busy, press_cnt
    );

    // Debouncer side: samples the button, produces toggle request and status.
    modport slave (
        input  btn, en,
        output t, db, busy, press_cnt
    );
endinterface

// File: rtl/btn_toggle_gen.sv
// Push-button debouncer that emits a single-cycle toggle request per
// accepted press. Raw button -> two-flop synchroniser -> four-state
// qualification FSM. A level change is accepted only after the synchronised
// input has differed from the debounced level for DB_CYCLES consecutive cycles.
module btn_toggle_gen #(
    parameter int DB_CYCLES = 4,
    parameter int CNT_W     = 8
) (
    input logic                 clk,
    input logic                 reset,
    btn_toggle_gen_if.slave     bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,  // db=0, stable
        ARM  = 2'd1,  // db=0, press being qualified
        HELD = 2'd2,  // db=1, stable
        REL  = 2'd3   // db=1, release being qualified
    } state_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             db_q, db_d;
    logic             t_q, t_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] press_cnt_q, press_cnt_d;

    logic             s;

    assign s = sync2_q;

    // Synchroniser next values: only sync1 ever looks at the raw button.
    always_comb begin
        sync1_d = bus.btn;
        sync2_d = sync1_q;
    end

    // Qualification FSM: next state, debounce counter, registered outputs.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        press_cnt_d = press_cnt_q;
        t_d         = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (s) begin
                    state_d = ARM;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d   = '0;
                end
            end
            ARM: begin
                if (!s) begin
                    // Glitch rejected before it lasted DB_CYCLES cycles.
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = HELD;
                    cnt_d       = '0;
                    t_d         = bus.en;
                    press_cnt_d = press_cnt_q + CNT_W'(1);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HELD: begin
                if (!s) begin
                    state_d = REL;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d   = '0;
                end
            end
            REL: begin
                if (s) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    // Release is accepted silently: no toggle request.
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Status outputs are registered copies of the next state's decode.
        db_d   = (state_d == HELD) || (state_d == REL);
        busy_d = (state_d == ARM)  || (state_d == REL);
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            db_q        <= 1'b0;
            t_q         <= 1'b0;
            busy_q      <= 1'b0;
            press_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values, making the synchroniser a true two-stage chain.
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            db_q        <= db_d;
            t_q         <= t_d;
            busy_q      <= busy_d;
            press_cnt_q <= press_cnt_d;
        end
    end

    assign bus.t         = t_q;
    assign bus.db        = db_q;
    assign bus.busy      = busy_q;
    assign bus.press_cnt = press_cnt_q;

endmodule
